// File: rtl/prga_decrypt_fsm.sv
// prga_decrypt_fsm: RC4 PRGA over a pre-shuffled S memory, XOR-decrypting MSG_LEN ROM bytes into RAM.
module prga_decrypt_fsm #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] s_q,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] enc_q,
  output logic [4:0] enc_address,
  output logic [4:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       busy,
  output logic       done
);
  typedef enum logic [3:0] {
    IDLE, INC_I, WAIT_I, READ_I, SET_J, WAIT_J, READ_J, WRITE_I,
    WRITE_J, SET_F, WAIT_F, READ_F, WRITE_DEC, NEXT, DONE
  } state_t;
  state_t state, state_n;
  logic [7:0] i, j, si, sj, f, e;
  logic [4:0] k;
  logic last;
  assign last = k == 5'(MSG_LEN - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // the per-byte states are encoded consecutively, so most steps are a plain increment
  always_comb
    state_n = state == IDLE ? (start ? INC_I : IDLE) :
              state == NEXT ? (last ? DONE : INC_I) :
              state == DONE ? (start ? DONE : IDLE) :
              state_t'(state + 4'd1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) {i, j, k, si, sj, f, e} <= '0;
    else
      case (state)
        IDLE: begin
          i <= 8'd0;
          j <= 8'd0;
          k <= 5'd0;
        end
        INC_I: i <= i + 8'd1;
        READ_I: si <= s_q;
        SET_J: j <= j + si;
        READ_J: sj <= s_q;
        READ_F: begin
          f <= s_q;
          e <= enc_q;
        end
        NEXT: if (!last) k <= k + 5'd1;
        default: ;
      endcase
  // addresses are held through the wait/read states to cover the two-cycle read latency
  always_comb begin
    s_address   = state == INC_I ? i + 8'd1 :
                  state inside {WAIT_I, READ_I, WRITE_I} ? i :
                  state == SET_J ? j + si :
                  state inside {WAIT_J, READ_J, WRITE_J} ? j :
                  state inside {SET_F, WAIT_F, READ_F} ? si + sj : 8'd0;
    s_data      = state == WRITE_I ? sj : state == WRITE_J ? si : 8'd0;
    s_wren      = state inside {WRITE_I, WRITE_J};
    enc_address = state inside {SET_F, WAIT_F, READ_F} ? k : 5'd0;
    dec_address = state == WRITE_DEC ? k : 5'd0;
    dec_data    = state == WRITE_DEC ? f ^ e : 8'd0;
    dec_wren    = state == WRITE_DEC;
    busy        = !(state inside {IDLE, DONE});
    done        = state == DONE;
  end
endmodule

// File: doc/prga_decrypt_fsm.md
PRGA_DECRYPT_FSM -- requirements
Module: prga_decrypt_fsm

Interface
REQ-001 Parameter MSG_LEN, default 32, number of message bytes decrypted per run; legal range 1..32.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level request; sampled in IDLE and DONE only.
REQ-005 s_q  input  8  read data from S memory (256x8, already shuffled by the key-schedule stage).
REQ-006 s_address  output  8  S memory address.
REQ-007 s_data  output  8  S memory write data.
REQ-008 s_wren  output  1  S memory write enable.
REQ-009 enc_q  input  8  encrypted-message ROM read data.
REQ-010 enc_address  output  5  encrypted-message ROM address.
REQ-011 dec_address  output  5  decrypted-message RAM address.
REQ-012 dec_data  output  8  decrypted byte.
REQ-013 dec_wren  output  1  decrypted RAM write enable.
REQ-014 busy  output  1  high in every state except IDLE and DONE.
REQ-015 done  output  1  high only in DONE.

Function
REQ-016 The block SHALL run the RC4 PRGA: per byte k, i=i+1; j=j+S[i]; swap S[i],S[j]; dec[k]=S[S[i]+S[j]] XOR enc[k].
REQ-017 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-018 Memory model: synchronous read; s_q/enc_q SHALL be sampled at the edge ending the READ state, two cycles after the address first appears.
REQ-019 States, one cycle each: IDLE, INC_I, WAIT_I, READ_I, SET_J, WAIT_J, READ_J, WRITE_I, WRITE_J, SET_F, WAIT_F, READ_F, WRITE_DEC, NEXT, DONE.
REQ-020 IDLE: i=0, j=0, k=0; go to INC_I when start=1, else stay.
REQ-021 INC_I: s_address=i+1, i<=i+1. READ_I: si<=s_q.
REQ-022 SET_J: j<=j+si, s_address=j+si. READ_J: sj<=s_q.
REQ-023 WRITE_I: s_address=i, s_data=sj, s_wren=1. WRITE_J: s_address=j, s_data=si, s_wren=1.
REQ-024 SET_F: s_address=si+sj, enc_address=k. READ_F: f<=s_q, e<=enc_q.
REQ-025 WRITE_DEC: dec_address=k, dec_data=f XOR e, dec_wren=1.
REQ-026 NEXT: if k==MSG_LEN-1 go DONE, else k<=k+1 and go INC_I.
REQ-027 DONE: hold done=1; return to IDLE when start=0.
REQ-028 s_wren high only in WRITE_I/WRITE_J; dec_wren high only in WRITE_DEC; each is a single-cycle pulse.
REQ-029 i, j and si+sj SHALL wrap modulo 256 (8-bit truncation); k is 5-bit and never wraps within a run.
REQ-030 i==j: both writes SHALL target the same address, leaving S[i] unchanged.
REQ-031 Throughput: exactly 13 cycles per byte; byte k written in cycle 13k+12 after the edge sampling start; done first high in cycle 13*MSG_LEN+1.
REQ-032 start changes while busy SHALL be ignored.

Reset
REQ-033 reset low SHALL immediately force IDLE, i=j=k=0, and all outputs 0 (s_wren, dec_wren, busy, done low), including mid-run.
REQ-034 After reset release, no memory writes SHALL occur until start is sampled high in IDLE.

Verification
REQ-035 S[n]=n, enc all 0x00, start=1 -> dec[0]=0x02 in cycle 12, dec[1]=0x05 in cycle 25; S[2]=0x03, S[3]=0x02 after byte 1.
REQ-036 Same S, enc[0]=0xFF -> dec[0]=0xFD.
REQ-037 Full 32-byte run vs software RC4 model with key 0x000249 -> all 32 dec bytes match; done high at cycle 417, busy low.
REQ-038 Reset asserted during WRITE_I of byte 5 -> s_wren/dec_wren drop asynchronously; state IDLE; rerun from start gives correct results only if S is reloaded.
REQ-039 start held high through DONE -> done stays high, no new run; start low -> IDLE next cycle; start high -> new run begins with i=j=0.
REQ-040 S crafted so j+S[i] overflows (S[1]=0xFF, j=0x10) -> j=0x0F, wrap verified; i==j case leaves S unchanged.
